// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the CPU-side request ports (instruction fetch and
// data) and the memory-side bus of mem_port_arbiter.
//   if_*   : fetch request/address in, read data/ack out
//   d_*    : data request/we/address/wdata in, read data/ack out
//   mem_*  : strobe/we/address/wdata out, read data/ready in
//   stall  : CPU stall request out
//   err    : sticky timeout flag out
// slave modport is the arbiter's view; master is the CPU/memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              stall;
  logic              err;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
           stall, err
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata,
           stall, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between an instruction-fetch
// port and a data (load/store) port. Requests are sampled only in IDLE; ties
// alternate using the last grant. Each access holds mem_en until mem_ready or
// until MAX_WAIT cycles elapse, in which case the access is aborted with zero
// read data, the ack still pulses, and the sticky err flag is set.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-low
//   bus  : mem_port_arbiter_if.slave (CPU request ports + memory bus)
module mem_port_arbiter #(
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_port_arbiter_if.slave     bus
);

  localparam int CNT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, IF_ACC, D_ACC, RESP} state_e;
  typedef enum logic {GNT_IF = 1'b0, GNT_D = 1'b1} grant_e;

  state_e            state_q;
  grant_e            last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic              if_ack_q;
  logic              d_ack_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  wait_q;

  logic [CNT_W-1:0]  wait_d;
  logic              timeout;
  grant_e            grant_sel_d;

  always_comb begin
    wait_d  = wait_q + CNT_W'(1);
    // Abort in the cycle whose missing ready would bring the count to MAX_WAIT,
    // so mem_en is high for exactly MAX_WAIT cycles.
    timeout = (wait_d == CNT_W'(MAX_WAIT));
    // Data wins when alone, or on a tie if fetch was granted last.
    grant_sel_d = (bus.d_req && (!bus.if_req || last_grant_q == GNT_IF)) ? GNT_D : GNT_IF;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_D;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      err_q        <= 1'b0;
      wait_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            wait_q       <= '0;
            mem_en_q     <= 1'b1;
            last_grant_q <= grant_sel_d;
            if (grant_sel_d == GNT_D) begin
              state_q  <= D_ACC;
              addr_q   <= bus.d_addr;
              wdata_q  <= bus.d_wdata;
              mem_we_q <= bus.d_we;
            end else begin
              state_q  <= IF_ACC;
              addr_q   <= bus.if_addr;
              wdata_q  <= '0;
              mem_we_q <= 1'b0;
            end
          end
        end

        IF_ACC, D_ACC: begin
          if (bus.mem_ready || timeout) begin
            state_q  <= RESP;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            if (!bus.mem_ready) begin
              err_q <= 1'b1;
            end
            if (state_q == IF_ACC) begin
              if_rdata_q <= bus.mem_ready ? bus.mem_rdata : '0;
              if_ack_q   <= 1'b1;
            end else begin
              // A store leaves the load-data register untouched.
              if (!mem_we_q) begin
                d_rdata_q <= bus.mem_ready ? bus.mem_rdata : '0;
              end
              d_ack_q <= 1'b1;
            end
          end else begin
            wait_q <= wait_d;
          end
        end

        RESP: begin
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
          state_q  <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.err       = err_q;
  assign bus.stall     = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(12), .DATA_W(16)) bus ();

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(16), .MAX_WAIT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [11:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [11:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        e_en;
    logic        e_we;
    logic [11:0] e_addr;
    logic        e_iack;
    logic        e_dack;
    logic [15:0] e_irdata;
    logic [15:0] e_drdata;
    logic        e_stall;
    logic        e_err;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  int pass_cnt  = 0;
  int total_cnt = 0;

  function automatic vec_t mk(
    input logic r, input logic ir, input logic [11:0] ia,
    input logic dr, input logic dw, input logic [11:0] da, input logic [15:0] dwd,
    input logic [15:0] mr, input logic rdy,
    input logic en, input logic we, input logic [11:0] ad, input logic iack,
    input logic dack, input logic [15:0] ird, input logic [15:0] drd,
    input logic st, input logic er);
    vec_t v;
    v.rst = r; v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw;
    v.d_addr = da; v.d_wdata = dwd; v.mem_rdata = mr; v.mem_ready = rdy;
    v.e_en = en; v.e_we = we; v.e_addr = ad; v.e_iack = iack; v.e_dack = dack;
    v.e_irdata = ird; v.e_drdata = drd; v.e_stall = st; v.e_err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_cnt, ack_cnt, en_cnt;
    bit got;

    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.mem_rdata = '0; bus.mem_ready = 0;

    // rst,ifq,ifa,  dq,dw,da,  dwd,rdata, rdy | en,we,addr,iack,dack,irdata,drdata,stall,err
    vecs[0]  = mk(0,0,12'h000,0,0,12'h000,0,16'h0000,0, 0,0,12'h000,0,0,16'h0000,16'h0000,0,0);
    vecs[1]  = mk(0,0,12'h000,0,0,12'h000,0,16'h0000,0, 0,0,12'h000,0,0,16'h0000,16'h0000,0,0);
    // single fetch, zero-wait memory
    vecs[2]  = mk(1,1,12'h010,0,0,12'h000,0,16'hBEEF,1, 0,0,12'h000,0,0,16'h0000,16'h0000,1,0);
    vecs[3]  = mk(1,1,12'h010,0,0,12'h000,0,16'hBEEF,1, 1,0,12'h010,0,0,16'h0000,16'h0000,1,0);
    vecs[4]  = mk(1,1,12'h010,0,0,12'h000,0,16'hBEEF,1, 0,0,12'h010,1,0,16'hBEEF,16'h0000,0,0);
    vecs[5]  = mk(1,0,12'h000,0,0,12'h000,0,16'hBEEF,1, 0,0,12'h010,0,0,16'hBEEF,16'h0000,0,0);
    // asynchronous reset, then both ports held: IF, D, IF, D
    vecs[6]  = mk(0,0,12'h000,0,0,12'h000,0,16'h0000,0, 0,0,12'h000,0,0,16'h0000,16'h0000,0,0);
    vecs[7]  = mk(1,1,12'h030,1,0,12'h040,0,16'hA001,1, 0,0,12'h000,0,0,16'h0000,16'h0000,1,0);
    vecs[8]  = mk(1,1,12'h030,1,0,12'h040,0,16'hA002,1, 1,0,12'h030,0,0,16'h0000,16'h0000,1,0);
    vecs[9]  = mk(1,1,12'h030,1,0,12'h040,0,16'hA003,1, 0,0,12'h030,1,0,16'hA002,16'h0000,1,0);
    vecs[10] = mk(1,1,12'h030,1,0,12'h040,0,16'hA004,1, 0,0,12'h030,0,0,16'hA002,16'h0000,1,0);
    vecs[11] = mk(1,1,12'h030,1,0,12'h040,0,16'hA005,1, 1,0,12'h040,0,0,16'hA002,16'h0000,1,0);
    vecs[12] = mk(1,1,12'h030,1,0,12'h040,0,16'hA006,1, 0,0,12'h040,0,1,16'hA002,16'hA005,1,0);
    vecs[13] = mk(1,1,12'h030,1,0,12'h040,0,16'hA007,1, 0,0,12'h040,0,0,16'hA002,16'hA005,1,0);
    vecs[14] = mk(1,1,12'h030,1,0,12'h040,0,16'hA008,1, 1,0,12'h030,0,0,16'hA002,16'hA005,1,0);
    vecs[15] = mk(1,1,12'h030,1,0,12'h040,0,16'hA009,1, 0,0,12'h030,1,0,16'hA008,16'hA005,1,0);
    vecs[16] = mk(1,1,12'h030,1,0,12'h040,0,16'hA00A,1, 0,0,12'h030,0,0,16'hA008,16'hA005,1,0);
    vecs[17] = mk(1,1,12'h030,1,0,12'h040,0,16'hA00B,1, 1,0,12'h040,0,0,16'hA008,16'hA005,1,0);
    vecs[18] = mk(1,1,12'h030,1,0,12'h040,0,16'hA00C,1, 0,0,12'h040,0,1,16'hA008,16'hA00B,1,0);
    vecs[19] = mk(1,0,12'h000,0,0,12'h000,0,16'h0000,0, 0,0,12'h040,0,0,16'hA008,16'hA00B,0,0);

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      rst = vecs[i].rst;
      bus.if_req = vecs[i].if_req;   bus.if_addr = vecs[i].if_addr;
      bus.d_req = vecs[i].d_req;     bus.d_we = vecs[i].d_we;
      bus.d_addr = vecs[i].d_addr;   bus.d_wdata = vecs[i].d_wdata;
      bus.mem_rdata = vecs[i].mem_rdata; bus.mem_ready = vecs[i].mem_ready;
      #1;
      chk($sformatf("v%0d mem_en", i),   32'(bus.mem_en),   32'(vecs[i].e_en));
      chk($sformatf("v%0d mem_we", i),   32'(bus.mem_we),   32'(vecs[i].e_we));
      chk($sformatf("v%0d mem_addr", i), 32'(bus.mem_addr), 32'(vecs[i].e_addr));
      chk($sformatf("v%0d if_ack", i),   32'(bus.if_ack),   32'(vecs[i].e_iack));
      chk($sformatf("v%0d d_ack", i),    32'(bus.d_ack),    32'(vecs[i].e_dack));
      chk($sformatf("v%0d if_rdata", i), 32'(bus.if_rdata), 32'(vecs[i].e_irdata));
      chk($sformatf("v%0d d_rdata", i),  32'(bus.d_rdata),  32'(vecs[i].e_drdata));
      chk($sformatf("v%0d stall", i),    32'(bus.stall),    32'(vecs[i].e_stall));
      chk($sformatf("v%0d err", i),      32'(bus.err),      32'(vecs[i].e_err));
      @(negedge clk);
    end

    // Store with three wait cycles; live address/data change mid-access.
    bus.d_req = 1; bus.d_we = 1; bus.d_addr = 12'h020; bus.d_wdata = 16'h1234;
    bus.mem_rdata = 16'h5555; bus.mem_ready = 0;
    #1;
    chk("st idle mem_en", 32'(bus.mem_en), 32'd0);
    chk("st idle stall",  32'(bus.stall),  32'd1);
    @(negedge clk);
    we_cnt = 0; ack_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin bus.d_addr = 12'h0FF; bus.d_wdata = 16'h0000; end
      bus.mem_ready = (k == 3);
      #1;
      if (bus.mem_we) we_cnt++;
      if (bus.d_ack) ack_cnt++;
      chk($sformatf("st acc%0d mem_addr", k),  32'(bus.mem_addr),  32'h020);
      chk($sformatf("st acc%0d mem_wdata", k), 32'(bus.mem_wdata), 32'h1234);
      @(negedge clk);
    end
    bus.mem_ready = 0;
    #1;
    if (bus.d_ack) ack_cnt++;
    chk("st resp d_ack",   32'(bus.d_ack),   32'd1);
    chk("st resp mem_we",  32'(bus.mem_we),  32'd0);
    chk("st resp d_rdata", 32'(bus.d_rdata), 32'hA00B);
    @(negedge clk);
    bus.d_req = 0; bus.d_we = 0;
    #1;
    if (bus.d_ack) ack_cnt++;
    chk("st mem_we cycles", 32'(we_cnt),  32'd4);
    chk("st d_ack count",   32'(ack_cnt), 32'd1);
    chk("st after err",     32'(bus.err), 32'd0);
    @(negedge clk);

    // Memory never ready: timeout abort after 15 strobe cycles.
    bus.if_req = 1; bus.if_addr = 12'h050; bus.mem_rdata = 16'h7777; bus.mem_ready = 0;
    en_cnt = 0; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      #1;
      if (bus.mem_en) en_cnt++;
      if (bus.if_ack) begin
        got = 1;
        chk("to if_rdata", 32'(bus.if_rdata), 32'h0);
        bus.if_req = 0;
      end
      @(negedge clk);
    end
    chk("to ack seen",       32'(got),     32'd1);
    chk("to mem_en cycles",  32'(en_cnt),  32'd15);
    chk("to err set",        32'(bus.err), 32'd1);

    // A good access afterwards leaves err set.
    bus.if_req = 1; bus.if_addr = 12'h070; bus.mem_rdata = 16'h1357; bus.mem_ready = 1;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      #1;
      if (bus.if_ack) begin
        got = 1;
        chk("good if_rdata", 32'(bus.if_rdata), 32'h1357);
        chk("good err held", 32'(bus.err),      32'd1);
        bus.if_req = 0;
      end
      @(negedge clk);
    end
    chk("good ack seen", 32'(got), 32'd1);

    // Reset asserted in the middle of a data access.
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 12'h060; bus.mem_ready = 0;
    bus.mem_rdata = 16'h2468;
    @(negedge clk);
    #1;
    chk("rs acc mem_en", 32'(bus.mem_en), 32'd1);
    chk("rs acc err",    32'(bus.err),    32'd1);
    #2;
    rst = 0;
    #1;
    chk("rs mem_en",   32'(bus.mem_en),   32'd0);
    chk("rs err",      32'(bus.err),      32'd0);
    chk("rs d_ack",    32'(bus.d_ack),    32'd0);
    chk("rs mem_addr", 32'(bus.mem_addr), 32'h0);
    @(negedge clk);
    rst = 1;
    #1;
    chk("rs rel mem_en", 32'(bus.mem_en), 32'd0);
    chk("rs rel d_ack",  32'(bus.d_ack),  32'd0);
    @(negedge clk);
    bus.mem_ready = 1;
    #1;
    chk("rs reissue mem_en",   32'(bus.mem_en),   32'd1);
    chk("rs reissue mem_addr", 32'(bus.mem_addr), 32'h060);
    @(negedge clk);
    #1;
    chk("rs reissue d_ack",   32'(bus.d_ack),   32'd1);
    chk("rs reissue d_rdata", 32'(bus.d_rdata), 32'h2468);
    bus.d_req = 0; bus.mem_ready = 0;
    @(negedge clk);
    #1;
    chk("rs final d_ack", 32'(bus.d_ack), 32'd0);
    chk("rs final stall", 32'(bus.stall), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, memory address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 Parameter MAX_WAIT, default 15, maximum cycles in an access state before timeout abort.
REQ-004 The port list SHALL be as follows; one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- if_req  in  1  instruction-fetch request, held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch read data, valid with if_ack.
- if_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request (ldm/stm), held until d_ack.
- d_we  in  1  1=store, 0=load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data, valid with d_ack.
- d_ack  out  1  one-cycle data completion pulse.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- mem_ready  in  1  memory completes the access this cycle.
- stall  out  1  CPU stall request.
- err  out  1  sticky timeout flag.

Function
REQ-005 FSM states SHALL be IDLE, IF_ACC, D_ACC, RESP.
REQ-006 IDLE: only d_req -> D_ACC; only if_req -> IF_ACC; neither -> stay IDLE.
REQ-007 Both requests in IDLE SHALL go to the requester not granted last (last_grant register, updated on every grant).
REQ-008 On grant, the winner's addr, we (0 for fetch) and wdata SHALL be latched; the memory outputs come from the latch, not from live inputs.
REQ-009 In IF_ACC/D_ACC: mem_en=1, mem_we=latched we; otherwise mem_en=0 and mem_we=0.
REQ-010 mem_ready=1 in an ACC state: mem_rdata is captured into the granted port's rdata register and the FSM goes to RESP.
REQ-011 RESP SHALL pulse the granted port's ack for exactly one cycle, then go to IDLE; both acks are never high together.
REQ-012 Minimum latency: req sampled in IDLE at cycle N, mem_en at N+1 (ready same cycle), ack at N+2.
REQ-013 A req still high in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-014 Requests are only sampled in IDLE; requests arriving mid-access wait.
REQ-015 A wait counter SHALL clear on entry to an ACC state and increment each ACC cycle without mem_ready.
- When the count reaches MAX_WAIT: abort, drop mem_en, load rdata=0, go to RESP (ack still pulses), set err.
REQ-016 err SHALL stay high until reset.
REQ-017 stall = (if_req & ~if_ack) | (d_req & ~d_ack), combinational.
REQ-018 On a store, d_rdata SHALL keep its previous value.
REQ-019 The wait counter SHALL be wide enough for MAX_WAIT with no wrap.

Reset
REQ-020 rst low SHALL immediately force: state IDLE, mem_en=0, mem_we=0, both acks 0, err=0, if_rdata=0, d_rdata=0, latched addr/wdata=0, wait counter 0, last_grant=data.
- First tie after reset therefore goes to instruction fetch.
REQ-021 Reset asserted mid-access SHALL abort the access with no ack; the requester re-issues after reset.

Verification
REQ-022 if_req with if_addr=0x010, mem_ready tied 1, mem_rdata=0xBEEF -> mem_en at N+1 with mem_addr=0x010; if_ack and if_rdata=0xBEEF at N+2; stall high N..N+1, low at N+2.
REQ-023 d_req store, d_addr=0x020, d_wdata=0x1234, mem_ready after 3 wait cycles -> mem_we=1 for 4 cycles, one d_ack, d_rdata unchanged.
REQ-024 if_req and d_req both held from reset release, 1-cycle memory -> grant order IF, D, IF, D; acks alternate with no overlap.
REQ-025 mem_ready held 0 with MAX_WAIT=15 -> mem_en high 15 cycles then drops; ack pulses with rdata=0; err=1 and stays 1 across later good accesses.
REQ-026 rst driven low during D_ACC -> mem_en=0 and state IDLE before the next clock edge, no d_ack, err=0.
